load_unit: RTL

//  Load-side counterpart of the store lane/mask controller: issues a word-aligned read to data

---
 rtl/load_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// RV32I load unit: issues one word-aligned read over a req/gnt/rvalid handshake and
// returns the sign/zero-extended byte, half or word, flagging misaligned, illegal and timed-out loads.
module load_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [2:0]  ld_func3,
   input  logic [31:0] ld_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        ld_done,
   output logic [31:0] ld_rdata,
   output logic [1:0]  ld_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        r_state;
   logic [2:0]    r_func3;
   logic [31:0]   r_addr;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_rdata;
   logic [1:0]    r_err;

   logic          w_illegal;
   logic          w_misaligned;
   logic          w_capture;
   logic          w_timeout;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_ext;

   assign ld_ready = (r_state == S_IDLE);
   assign mem_req  = (r_state == S_REQ);
   assign ld_done  = (r_state == S_DONE);
   assign mem_addr = {r_addr[31:2], 2'b00};
   assign ld_rdata = r_rdata;
   assign ld_err   = r_err;

   // Legality is judged on the incoming request, illegal taking precedence over misaligned.
   assign w_illegal    = (ld_func3 == 3'b011) || (ld_func3 == 3'b110) || (ld_func3 == 3'b111);
   assign w_misaligned = (((ld_func3 == F3_LH) || (ld_func3 == F3_LHU)) && ld_addr[0]) ||
                         ((ld_func3 == F3_LW) && (ld_addr[1:0] != 2'b00));

   assign w_capture = ((r_state == S_REQ) && mem_gnt && mem_rvalid) ||
                      ((r_state == S_WAIT) && mem_rvalid);
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

   assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
   assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      // NOTE: default assignment first so every path drives w_ext and no latch is inferred.
      w_ext = mem_rdata;
      case (r_func3)
         F3_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
         F3_LH:   w_ext = {{16{w_half[15]}}, w_half};
         F3_LBU:  w_ext = {24'd0, w_byte};
         F3_LHU:  w_ext = {16'd0, w_half};
         default: w_ext = mem_rdata;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_func3 <= 3'b000;
         r_addr  <= 32'd0;
         r_cnt   <= '0;
         r_rdata <= 32'd0;
         r_err   <= ERR_OK;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ld_valid) begin
                  r_func3 <= ld_func3;
                  r_addr  <= ld_addr;
                  r_cnt   <= '0;
                  if (w_illegal) begin
                     r_state <= S_DONE;
                     r_err   <= ERR_ILLEGAL;
                     r_rdata <= 32'd0;
                  end else if (w_misaligned) begin
                     r_state <= S_DONE;
                     r_err   <= ERR_MISALIGN;
                     r_rdata <= 32'd0;
                  end else begin
                     r_state <= S_REQ;
                  end
               end
            end
            S_REQ, S_WAIT: begin
               if (w_capture) begin
                  r_state <= S_DONE;
                  r_err   <= ERR_OK;
                  r_rdata <= w_ext;
               end else if (w_timeout) begin
                  r_state <= S_DONE;
                  r_err   <= ERR_TIMEOUT;
                  r_rdata <= 32'd0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if ((r_state == S_REQ) && mem_gnt) begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
